// File: rtl/fifo_uart_pkg.sv
// Shared state encoding and frame shape for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_counter #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic             bit_end
);

   assign bit_end = (count == CNT_W'(CLKS_PER_BIT - 1));

   // Wrapping at bit_end makes every bit-to-bit state change start from zero.
   always_ff @(posedge clock) begin
      if (rst || clear) begin
         count <= '0;
      end else if (bit_end) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a synchronous FIFO and serialises each one as an 8N1 UART frame.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_rd,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   tx_state_t         state;
   logic [DATA_W-1:0] shreg;
   logic [2:0]        bit_idx;
   logic [CNT_W-1:0]  baud_count;
   logic              bit_end;
   logic              baud_clear;

   // The baud counter only runs while a bit is on the line.
   assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

   baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .CNT_W       (CNT_W)
   ) u_baud (
      .clock  (clock),
      .rst    (rst),
      .clear  (baud_clear),
      .count  (baud_count),
      .bit_end(bit_end)
   );

   // Outputs are set one cycle ahead of the state they belong to, so tx and
   // done change on the same edge as the state register.
   always_ff @(posedge clock) begin
      if (rst) begin
         state   <= IDLE;
         tx      <= 1'b1;
         fifo_rd <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         shreg   <= '0;
         bit_idx <= '0;
      end else begin
         fifo_rd <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  state   <= FETCH;
                  fifo_rd <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            FETCH: begin
               state <= LOAD;
            end
            LOAD: begin
               shreg <= fifo_dout;
               tx    <= 1'b0;
               state <= START;
            end
            START: begin
               if (bit_end) begin
                  tx      <= shreg[0];
                  shreg   <= {1'b0, shreg[DATA_W-1:1]};
                  bit_idx <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'(DATA_BITS - 1)) begin
                     tx      <= 1'b1;
                     bit_idx <= '0;
                     state   <= STOP;
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= {1'b0, shreg[DATA_W-1:1]};
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            STOP: begin
               if (bit_idx == 3'(STOP_BITS - 1) &&
                   baud_count == CNT_W'(CLKS_PER_BIT - 2)) begin
                  done <= 1'b1;
               end
               if (bit_end) begin
                  if (bit_idx == 3'(STOP_BITS - 1)) begin
                     busy    <= 1'b0;
                     bit_idx <= '0;
                     state   <= IDLE;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed and randomized checks of fifo_uart_tx against a queue FIFO and a mid-bit UART decoder.
module tb_fifo_uart_tx;

   localparam int N = 4;
   localparam int P = 10 * N + 3;

   logic       clock;
   logic       rst;
   logic       fifo_empty;
   logic [7:0] fifo_dout;
   logic       fifo_rd;
   logic       tx;
   logic       busy;
   logic       done;

   logic       holdEmpty  = 1'b0;
   logic       modelEmpty = 1'b1;
   logic [7:0] fifoQ[$];
   logic [7:0] rxQ[$];
   logic [7:0] expQ[$];
   logic [7:0] rxByte;
   int         vectors    = 0;
   int         miscompares = 0;
   int         rdCount    = 0;
   int         doneCount  = 0;

   fifo_uart_tx #(
      .CLKS_PER_BIT(N),
      .DATA_W      (8)
   ) dut (
      .clock     (clock),
      .rst       (rst),
      .fifo_empty(fifo_empty),
      .fifo_dout (fifo_dout),
      .fifo_rd   (fifo_rd),
      .tx        (tx),
      .busy      (busy),
      .done      (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign fifo_empty = holdEmpty | modelEmpty;

   // Behavioural FIFO: a read strobe seen mid-cycle presents the next word for the following cycle.
   always @(negedge clock) begin
      if (fifo_rd === 1'b1 && fifoQ.size() > 0) fifo_dout = fifoQ.pop_front();
      modelEmpty = (fifoQ.size() == 0);
   end

   always @(negedge clock) begin
      if (fifo_rd === 1'b1) rdCount++;
      if (done === 1'b1) doneCount++;
   end

   // Receiver: find the start bit, then sample every bit near its middle.
   always begin
      @(negedge clock);
      if (tx === 1'b0) begin
         repeat (N / 2) @(negedge clock);
         for (int i = 0; i < 8; i++) begin
            repeat (N) @(negedge clock);
            rxByte[i] = tx;
         end
         repeat (N) @(negedge clock);
         rxQ.push_back(rxByte);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic expTx(input int k, input logic [7:0] b);
      int j;
      if (k < 2 || k >= 2 + 10 * N) return 1'b1;
      j = (k - 2) / N;
      if (j == 0) return 1'b0;
      if (j <= 8) return b[j-1];
      return 1'b1;
   endfunction

   task automatic applyStimulus(input logic [7:0] b);
      fifoQ.push_back(b);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      int rd0;
      int d0;
      int guard;
      int gapOnes;
      logic [7:0] b;
      logic [7:0] obsByte;

      rst       = 1'b1;
      fifo_dout = 8'h00;
      applyStimulus(8'hA5);

      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         checkOutput("reset_tx", tx, 1);
         checkOutput("reset_rd", fifo_rd, 0);
         checkOutput("reset_busy", busy, 0);
         checkOutput("reset_done", done, 0);
      end
      checkOutput("reset_fifo_nonempty", fifo_empty, 0);
      @(posedge clock);
      #1 rst = 1'b0;

      @(negedge clock);
      checkOutput("release_cycle0_rd", fifo_rd, 0);
      for (int k = 0; k <= 45; k++) begin
         @(negedge clock);
         checkOutput($sformatf("single_tx_k%0d", k), tx, expTx(k, 8'hA5));
         checkOutput($sformatf("single_rd_k%0d", k), fifo_rd, (k == 0));
         checkOutput($sformatf("single_busy_k%0d", k), busy, (k <= 10 * N + 1));
         checkOutput($sformatf("single_done_k%0d", k), done, (k == 10 * N + 1));
      end
      waitCycles(2);
      checkOutput("single_rd_count", rdCount, 1);
      checkOutput("single_done_count", doneCount, 1);

      // Two queued bytes go out back to back with a three-cycle idle gap.
      rd0 = rdCount;
      d0  = doneCount;
      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      guard = 0;
      do begin
         @(negedge clock);
         guard++;
      end while (fifo_rd !== 1'b1 && guard < 20);
      checkOutput("b2b_first_rd", fifo_rd, 1);
      gapOnes = 0;
      for (int k = 0; k < 2 * P + 4; k++) begin
         if (k > 0) @(negedge clock);
         b = (k / P == 0) ? 8'h00 : 8'hFF;
         checkOutput($sformatf("b2b_tx_k%0d", k), tx, (k >= 2 * P) ? 1'b1 : expTx(k % P, b));
         checkOutput($sformatf("b2b_rd_k%0d", k), fifo_rd, (k % P == 0 && k < 2 * P));
         if (k >= 2 + 9 * N && k < P + 2 && tx === 1'b1) gapOnes++;
      end
      checkOutput("b2b_gap_beyond_stop", gapOnes - N, 3);
      waitCycles(4);
      checkOutput("b2b_rd_count", rdCount - rd0, 2);
      checkOutput("b2b_done_count", doneCount - d0, 2);
      checkOutput("b2b_rx_size", rxQ.size(), 3);
      checkOutput("b2b_rx0", (rxQ.size() > 0) ? rxQ[0] : 8'hxx, 8'hA5);
      checkOutput("b2b_rx1", (rxQ.size() > 1) ? rxQ[1] : 8'hxx, 8'h00);
      checkOutput("b2b_rx2", (rxQ.size() > 2) ? rxQ[2] : 8'hxx, 8'hFF);
      rxQ.delete();

      // A byte waits behind a held-high empty flag.
      holdEmpty = 1'b1;
      applyStimulus(8'h3C);
      rd0 = rdCount;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         checkOutput("hold_rd", fifo_rd, 0);
         checkOutput("hold_tx", tx, 1);
         checkOutput("hold_busy", busy, 0);
      end
      @(posedge clock);
      #1 holdEmpty = 1'b0;
      @(negedge clock);
      checkOutput("hold_release_cycle0_rd", fifo_rd, 0);
      @(negedge clock);
      checkOutput("hold_release_cycle1_rd", fifo_rd, 1);

      // Reset lands during data bit 3 of 0x3C.
      repeat (18) @(posedge clock);
      @(negedge clock);
      checkOutput("midframe_tx_k18", tx, expTx(18, 8'h3C));
      checkOutput("midframe_busy_k18", busy, 1);
      @(posedge clock);
      #1 rst = 1'b1;
      @(negedge clock);
      @(negedge clock);
      checkOutput("midframe_reset_tx", tx, 1);
      checkOutput("midframe_reset_busy", busy, 0);
      checkOutput("midframe_reset_done", done, 0);
      @(posedge clock);
      #1 rst = 1'b0;
      rd0 = rdCount;
      d0  = doneCount;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         checkOutput("after_reset_tx", tx, 1);
         checkOutput("after_reset_busy", busy, 0);
      end
      waitCycles(1);
      checkOutput("after_reset_no_reread", rdCount - rd0, 0);
      checkOutput("after_reset_no_done", doneCount - d0, 0);
      rxQ.delete();

      // Random stream recovered by the receiver.
      rd0 = rdCount;
      d0  = doneCount;
      for (int i = 0; i < 10; i++) begin
         b = 8'($urandom_range(0, 49));
         expQ.push_back(b);
         applyStimulus(b);
      end
      guard = 0;
      while (doneCount - d0 < 10 && guard < 10 * P + 100) begin
         waitCycles(1);
         guard++;
      end
      waitCycles(5);
      checkOutput("random_rd_count", rdCount - rd0, 10);
      checkOutput("random_done_count", doneCount - d0, 10);
      checkOutput("random_rx_size", rxQ.size(), 10);
      for (int i = 0; i < 10; i++) begin
         obsByte = (i < rxQ.size()) ? rxQ[i] : 8'hxx;
         checkOutput($sformatf("random_rx%0d", i), obsByte, expQ[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
